sram_zbt_controller: RTL and testbench
======================================

Name: sram_zbt_controller

Overview:
- Responder end of the arbiter-to-SRAM request interface; sits between the SRAM arbiter and the board ZBT SRAM pins.
- Accepts one request per cycle (read when write mask is 0000, write otherwise) and drives registered pin-level control.
- Returns read data in request order with fixed latency; inserts read-to-write bus turnaround and holds off requests during power-up.

Parameters:
- INIT_CYCLES, 16, cycles after reset with sram_ready low before the first accept.
- RD_LATENCY, 2, cycles from command cycle on pins to read data valid on sram_p_dq_in.
- WR_LATENCY, 2, cycles from command cycle on pins to the cycle write data must be driven.
- TURNAROUND, 1, minimum idle cycles between an accepted read and the next accepted write.

Ports:
- sram_clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- sram_addr_valid  in  1  request valid from arbiter
- sram_ready  out  1  request accepted this cycle when high together with valid
- sram_addr  in  18  word address
- sram_data_in  in  32  write data
- sram_write_mask  in  4  byte write enables, 0000 = read
- sram_data_out  out  32  read data, registered
- sram_data_out_valid  out  1  one-cycle read data strobe, no backpressure
- sram_p_addr  out  18  pin address, registered
- sram_p_ce_l  out  1  chip enable, active-low
- sram_p_we_l  out  1  write enable, active-low
- sram_p_bw_l  out  4  byte write enables, active-low
- sram_p_dq_out  out  32  data to pad driver
- sram_p_dq_oe  out  1  pad output enable
- sram_p_dq_in  in  32  data from pad

Behaviour:
- Clock and reset: one clock, sram_clock; reset is synchronous and active-high.
- Reset values:
  - sram_ready=0, sram_data_out_valid=0, sram_data_out=0.
  - sram_p_ce_l=1, sram_p_we_l=1, sram_p_bw_l=1111, sram_p_addr=0, sram_p_dq_oe=0, sram_p_dq_out=0.
  - All in-flight pipeline entries cleared; state=INIT.
- State machine:
  - INIT: counter counts INIT_CYCLES cycles, then moves to RUN.
  - RUN: handles all traffic; no other states.
  - Reset from any state returns to INIT.
- Accept rule: a request is accepted in cycle A iff sram_addr_valid && sram_ready.
- sram_ready is combinational: state==RUN && !hazard.
  - hazard = sram_addr_valid && sram_write_mask!=0 && turn_cnt!=0.
  - turn_cnt is loaded with TURNAROUND on each accepted read and decrements to 0 when not reloaded.
  - Reads are never stalled in RUN.
- Command cycle C=A+1 (registered):
  - sram_p_ce_l=0, sram_p_addr=sram_addr.
  - Read: sram_p_we_l=1, bw_l=1111.
  - Write: sram_p_we_l=0, bw_l=~sram_write_mask.
  - With no accept in A, cycle C drives ce_l=1, we_l=1, bw_l=1111 and holds the last address.
- Write data: sram_data_in is delayed in a shift pipeline. In cycle C+WR_LATENCY, sram_p_dq_oe=1 and sram_p_dq_out=the write data, for exactly one cycle per write. Back-to-back writes keep oe high continuously.
- Read data: sram_p_dq_in is captured at the end of cycle C+RD_LATENCY. In cycle C+RD_LATENCY+1, sram_data_out_valid=1 for one cycle with the captured word. Default total is A+4.
- Ordering: reads complete strictly in acceptance order; one valid strobe per accepted read; none for writes.
- Throughput: one command per cycle. Back-to-back reads give back-to-back valid strobes.
- Read followed by write: the write is stalled TURNAROUND cycles. Write followed by read: no stall.
- Reset mid-operation: in-flight reads are discarded, with no sram_data_out_valid after the reset cycle; dq_oe drops to 0 in the cycle after reset is sampled.
- Address and data are passed through unmodified. No width arithmetic; mask bit i maps to byte [8i+7:8i].

Test Plan:
- Reset, hold valid=1: sram_ready=0 for 16 cycles after reset deasserts, first accept on cycle 17; pins idle (ce_l=1, bw_l=1111, oe=0) throughout INIT.
- Write addr 0x00010, data 0xDEADBEEF, mask 1111 accepted at A: cycle A+1 has ce_l=0, we_l=0, bw_l=0000, p_addr=0x00010; cycle A+3 has oe=1, dq_out=0xDEADBEEF; no data_out_valid.
- Read addr 0x00010 accepted at A, bench model returns 0xCAFEF00D on dq_in in cycle A+3: data_out_valid=1 only in A+4 with sram_data_out=0xCAFEF00D.
- Four back-to-back reads, addrs 1..4, model returns addr*0x11111111: four consecutive valid strobes with 0x11111111..0x44444444 in order.
- Read accepted at A, write requested at A+1: sram_ready=0 in A+1, write accepted A+2; write then read back-to-back accepted with no stall; dq_oe never high in a cycle where model drives dq_in.
- Three reads in flight, reset pulsed one cycle: no sram_data_out_valid afterwards, oe=0, ready=0 and INIT re-runs for 16 cycles.

Source files
------------

// File: rtl/sram_zbt_controller_if.sv
// Arbiter-to-SRAM request/response bundle.
// The arbiter side is master and the controller side is slave.
interface sram_zbt_controller_if;
  logic        sram_addr_valid;
  logic        sram_ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_data_in;
  logic [3:0]  sram_write_mask;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;

  modport master (
    output sram_addr_valid,
    output sram_addr,
    output sram_data_in,
    output sram_write_mask,
    input  sram_ready,
    input  sram_data_out,
    input  sram_data_out_valid
  );

  modport slave (
    input  sram_addr_valid,
    input  sram_addr,
    input  sram_data_in,
    input  sram_write_mask,
    output sram_ready,
    output sram_data_out,
    output sram_data_out_valid
  );
endinterface

// File: rtl/sram_zbt_controller.sv
// ZBT SRAM controller: registered pin control, fixed-latency in-order reads,
// read-to-write turnaround and a power-up hold-off.
module sram_zbt_controller #(
  parameter int INIT_CYCLES = 16,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic        sram_clock,
  input  logic        reset,
  sram_zbt_controller_if.slave req,
  output logic [17:0] sram_p_addr,
  output logic        sram_p_ce_l,
  output logic        sram_p_we_l,
  output logic [3:0]  sram_p_bw_l,
  output logic [31:0] sram_p_dq_out,
  output logic        sram_p_dq_oe,
  input  logic [31:0] sram_p_dq_in
);

  localparam int CW = $clog2(INIT_CYCLES + 1);
  localparam int TW = $clog2(TURNAROUND + 2);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [CW-1:0]         init_cnt;
  logic [TW-1:0]         turn_cnt;
  logic                  is_wr;
  logic                  hazard;
  logic                  accept;
  logic [WR_LATENCY-1:0] wr_vld;
  logic [31:0]           wr_dat [WR_LATENCY];
  logic [RD_LATENCY:0]   rd_vld;

  assign is_wr  = |req.sram_write_mask;
  assign hazard = req.sram_addr_valid && is_wr
                  && (turn_cnt != '0);
  // Never claim an accept on a cycle that is being reset.
  assign req.sram_ready = !reset && (state == RUN)
                          && !hazard;
  assign accept = req.sram_addr_valid && req.sram_ready;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      state                   <= INIT;
      init_cnt                <= '0;
      turn_cnt                <= '0;
      sram_p_addr             <= '0;
      sram_p_ce_l             <= 1'b1;
      sram_p_we_l             <= 1'b1;
      sram_p_bw_l             <= 4'hf;
      sram_p_dq_out           <= '0;
      sram_p_dq_oe            <= 1'b0;
      wr_vld                  <= '0;
      rd_vld                  <= '0;
      req.sram_data_out       <= '0;
      req.sram_data_out_valid <= 1'b0;
      for (int i = 0; i < WR_LATENCY; i++)
        wr_dat[i] <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == CW'(INIT_CYCLES - 1))
            state <= RUN;
        end
        RUN: ;
        default: state <= INIT;
      endcase

      if (accept && !is_wr)
        turn_cnt <= TW'(TURNAROUND);
      else if (turn_cnt != '0)
        turn_cnt <= turn_cnt - 1'b1;

      sram_p_ce_l <= !accept;
      sram_p_we_l <= !(accept && is_wr);
      sram_p_bw_l <= (accept && is_wr)
                     ? ~req.sram_write_mask : 4'hf;
      if (accept)
        sram_p_addr <= req.sram_addr;

      // Stage 0 holds the command-cycle entry.
      wr_vld[0] <= accept && is_wr;
      wr_dat[0] <= req.sram_data_in;
      for (int i = 1; i < WR_LATENCY; i++) begin
        wr_vld[i] <= wr_vld[i-1];
        wr_dat[i] <= wr_dat[i-1];
      end
      sram_p_dq_oe <= wr_vld[WR_LATENCY-1];
      if (wr_vld[WR_LATENCY-1])
        sram_p_dq_out <= wr_dat[WR_LATENCY-1];

      rd_vld[0] <= accept && !is_wr;
      for (int i = 1; i <= RD_LATENCY; i++)
        rd_vld[i] <= rd_vld[i-1];
      req.sram_data_out_valid <= rd_vld[RD_LATENCY];
      if (rd_vld[RD_LATENCY])
        req.sram_data_out <= sram_p_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_zbt_controller.sv
// Randomized bench for sram_zbt_controller against a
// cycle-scheduled transaction model of the SRAM port.
module tb_sram_zbt_controller;

  localparam int INIT_CYCLES = 16;
  localparam int TURNAROUND  = 1;

  logic        clk;
  logic        rst;
  logic [17:0] p_addr;
  logic        p_ce_l;
  logic        p_we_l;
  logic [3:0]  p_bw_l;
  logic [31:0] p_dq_out;
  logic        p_dq_oe;
  logic [31:0] p_dq_in;

  sram_zbt_controller_if bus();

  sram_zbt_controller dut (
    .sram_clock    (clk),
    .reset         (rst),
    .req           (bus),
    .sram_p_addr   (p_addr),
    .sram_p_ce_l   (p_ce_l),
    .sram_p_we_l   (p_we_l),
    .sram_p_bw_l   (p_bw_l),
    .sram_p_dq_out (p_dq_out),
    .sram_p_dq_oe  (p_dq_oe),
    .sram_p_dq_in  (p_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Expected events, indexed by cycle number mod 8.
  bit        sl_cmd  [8];
  bit        sl_we   [8];
  bit [3:0]  sl_bw   [8];
  bit [17:0] sl_addr [8];
  bit        sl_wr   [8];
  bit [31:0] sl_wdat [8];
  bit        sl_rd   [8];
  bit [31:0] sl_rdat [8];
  bit        sl_drv  [8];
  bit [31:0] sl_dq   [8];

  bit [31:0] mem [bit [17:0]];
  bit [17:0] last_addr;
  int        t;
  int        last_rd;
  int        init_cnt;
  bit        post_rst;

  function automatic bit [31:0] mem_rd(input bit [17:0] a);
    bit [31:0] w;
    if (mem.exists(a)) w = mem[a];
    else w = {14'b0, a} * 32'h1111_1111;
    return w;
  endfunction

  function automatic void clr(input int s);
    sl_cmd[s] = 0; sl_we[s] = 0; sl_bw[s] = 4'hf;
    sl_addr[s] = '0; sl_wr[s] = 0; sl_wdat[s] = '0;
    sl_rd[s] = 0; sl_rdat[s] = '0;
    sl_drv[s] = 0; sl_dq[s] = '0;
  endfunction

  task automatic step(input bit v, input bit [17:0] a,
                      input bit [31:0] d, input bit [3:0] m,
                      input bit r);
    int s, s1, s3, s4;
    bit rdy_e, acc, drv;
    bit [31:0] dq, w;
    @(negedge clk);
    s = t % 8;
    if (sl_cmd[s]) last_addr = sl_addr[s];
    chk("ce_l", p_ce_l, sl_cmd[s] ? 1'b0 : 1'b1);
    chk("we_l", p_we_l, (sl_cmd[s] && sl_we[s]) ? 1'b0 : 1'b1);
    chk("bw_l", p_bw_l, sl_cmd[s] ? sl_bw[s] : 4'hf);
    chk("p_addr", p_addr, last_addr);
    chk("dq_oe", p_dq_oe, sl_wr[s]);
    if (sl_wr[s]) chk("dq_out", p_dq_out, sl_wdat[s]);
    chk("rd_valid", bus.sram_data_out_valid, sl_rd[s]);
    if (sl_rd[s]) chk("rd_data", bus.sram_data_out, sl_rdat[s]);
    if (post_rst) begin
      chk("rst_data_out", bus.sram_data_out, 32'h0);
      chk("rst_dq_out", p_dq_out, 32'h0);
    end
    drv = sl_drv[s];
    dq  = drv ? sl_dq[s] : $urandom;
    clr(s);
    rst                 = r;
    bus.sram_addr_valid = v;
    bus.sram_addr       = a;
    bus.sram_data_in    = d;
    bus.sram_write_mask = m;
    p_dq_in             = dq;
    #1;
    if (drv) chk("bus_conflict", p_dq_oe, 1'b0);
    rdy_e = !r && (init_cnt >= INIT_CYCLES)
            && !(v && m != 0 && (t - last_rd) <= TURNAROUND);
    chk("ready", bus.sram_ready, rdy_e);
    acc = v && rdy_e;
    if (r) begin
      for (int i = 0; i < 8; i++) clr(i);
      last_addr = '0;
      init_cnt  = 0;
      last_rd   = -100;
      post_rst  = 1;
    end else begin
      init_cnt++;
      post_rst = 0;
    end
    if (acc) begin
      s1 = (t + 1) % 8; s3 = (t + 3) % 8; s4 = (t + 4) % 8;
      sl_cmd[s1]  = 1;
      sl_addr[s1] = a;
      sl_we[s1]   = (m != 0);
      sl_bw[s1]   = ~m;
      if (m != 0) begin
        w = mem_rd(a);
        for (int i = 0; i < 4; i++)
          if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        mem[a] = w;
        sl_wr[s3]   = 1;
        sl_wdat[s3] = d;
      end else begin
        sl_drv[s3]  = 1;
        sl_dq[s3]   = mem_rd(a);
        sl_rd[s4]   = 1;
        sl_rdat[s4] = mem_rd(a);
        last_rd     = t;
      end
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 4'h0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.sram_addr_valid = 1'b0;
    bus.sram_addr       = '0;
    bus.sram_data_in    = '0;
    bus.sram_write_mask = '0;
    p_dq_in             = '0;
    for (int i = 0; i < 8; i++) clr(i);
    last_addr = '0;
    t = 0;
    last_rd = -100;
    init_cnt = 0;
    post_rst = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < INIT_CYCLES + 1; i++)
      step(1, 18'h3, '0, 4'h0, 0);
    idle(6);

    step(1, 18'h10, 32'hDEAD_BEEF, 4'hf, 0);
    idle(5);

    mem[18'h11] = 32'hCAFE_F00D;
    step(1, 18'h11, '0, 4'h0, 0);
    idle(5);

    for (int i = 1; i <= 4; i++) step(1, 18'(i), '0, 4'h0, 0);
    idle(6);

    step(1, 18'h20, '0, 4'h0, 0);
    step(1, 18'h21, 32'h1234_5678, 4'h5, 0);
    step(1, 18'h21, 32'h1234_5678, 4'h5, 0);
    step(1, 18'h21, '0, 4'h0, 0);
    idle(6);

    for (int i = 5; i <= 7; i++) step(1, 18'(i), '0, 4'h0, 0);
    step(0, '0, '0, 4'h0, 1);
    for (int i = 0; i < INIT_CYCLES + 4; i++)
      step(1, 18'h9, '0, 4'h0, 0);
    idle(6);

    for (int n = 0; n < 2500; n++) begin
      bit v, r;
      bit [3:0] m;
      v = ($urandom_range(0, 9) < 7);
      m = ($urandom_range(0, 1) == 0) ? 4'h0
          : 4'($urandom_range(1, 15));
      r = ($urandom_range(0, 399) == 0);
      step(v, 18'($urandom_range(0, 15)), $urandom, m, r);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
